// File: rtl/hyperram_pattern_tester.sv
// hyperram_pattern_tester: LFSR write/readback self-test for hyperram_intf_2; define HYPERRAM_TESTER_ERR_LOG_EN to build first-error capture
module hyperram_pattern_tester #(
  parameter int          ADDR_W     = 22,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] SEED       = 32'hACE1_2468,
  parameter int          WR_GAP     = 24,
  parameter int          RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              rd_sel,
  output logic              wr_sel,
  output logic              mem_sel,
  output logic              reg_sel,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              rd_data_valid
);
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, count_q, count_d, idx_q, idx_d, idx_nx, addr_q, addr_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d, err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic pass_q, pass_d, tmo_q, tmo_d, done_q, done_d, busy_q, busy_d;
  logic rd_sel_q, rd_sel_d, wr_sel_q, wr_sel_d;
  logic rd_fire, rd_miss, rd_bad;
`ifdef HYPERRAM_TESTER_ERR_LOG_EN
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [DATA_W-1:0] fed_q, fed_d;
`endif
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  assign idx_nx  = idx_q + 1'b1;
  assign rd_miss = !rd_data_valid;
  assign rd_bad  = rd_miss || (rd_data_in != lfsr_q[DATA_W-1:0]);
  assign rd_fire = rd_data_valid || (cnt_q == 16'(RD_TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q + 1'b1;
    err_d   = err_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
`ifdef HYPERRAM_TESTER_ERR_LOG_EN
    fea_d   = fea_q;
    fed_d   = fed_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        base_d  = base_addr;
        count_d = word_count;
        idx_d   = '0;
        lfsr_d  = SEED;
        cnt_d   = '0;
        err_d   = '0;
        pass_d  = 1'b0;
        tmo_d   = 1'b0;
`ifdef HYPERRAM_TESTER_ERR_LOG_EN
        fea_d   = '0;
        fed_d   = '0;
`endif
        state_d = (word_count == '0) ? S_DONE : S_WR_REQ;
      end
      S_WR_REQ: begin
        lfsr_d  = lfsr_step(lfsr_q);
        cnt_d   = '0;
        state_d = S_WR_GAP;
      end
      S_WR_GAP: if (cnt_q == 16'(WR_GAP - 1)) begin
        cnt_d   = '0;
        idx_d   = (idx_nx == count_q) ? '0 : idx_nx;
        lfsr_d  = (idx_nx == count_q) ? SEED : lfsr_q;
        state_d = (idx_nx == count_q) ? S_RD_REQ : S_WR_REQ;
      end
      S_RD_REQ: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: if (rd_fire) begin
        if (rd_bad) begin
          err_d = (err_q == 16'hFFFF) ? err_q : err_q + 1'b1;
`ifdef HYPERRAM_TESTER_ERR_LOG_EN
          // err_q never wraps back to zero, so zero marks the first failure of the run
          if (err_q == '0) begin
            fea_d = addr_q;
            fed_d = rd_miss ? '0 : rd_data_in;
          end
`endif
        end
        tmo_d   = tmo_q | rd_miss;
        lfsr_d  = lfsr_step(lfsr_q);
        cnt_d   = '0;
        idx_d   = idx_nx;
        state_d = (idx_nx == count_q) ? S_DONE : S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) pass_d = (err_d == '0);
    done_d   = state_d == S_DONE;
    busy_d   = state_d != S_IDLE;
    wr_sel_d = state_d == S_WR_REQ;
    rd_sel_d = state_d == S_RD_REQ;
    addr_d   = (wr_sel_d || rd_sel_d) ? base_d + idx_d : addr_q;
    wdata_d  = wr_sel_d ? lfsr_d[DATA_W-1:0] : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_sel_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rd_sel_q <= rd_sel_d;
      wr_sel_q <= wr_sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end
`ifdef HYPERRAM_TESTER_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fea_q <= '0;
      fed_q <= '0;
    end else begin
      fea_q <= fea_d;
      fed_q <= fed_d;
    end
  end
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = tmo_q;
  assign err_count   = err_q;
  assign rd_sel      = rd_sel_q;
  assign wr_sel      = wr_sel_q;
  assign mem_sel     = rd_sel_q | wr_sel_q;
  assign reg_sel     = 1'b0;
  assign addr_out    = addr_q;
  assign wr_data_out = wdata_q;
endmodule

// File: tb/tb_hyperram_pattern_tester.sv
// tb_hyperram_pattern_tester: scoreboard bench with a HyperRAM echo model and fault injection
module tb_hyperram_pattern_tester;
  localparam int AW = 22, DW = 32, G = 24, TO = 255, LAT = 10;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  logic clk, reset, start, busy, done, pass, timeout, rd_sel, wr_sel, mem_sel, reg_sel, rd_data_valid;
  logic [AW-1:0] base_addr, word_count, first_err_addr, addr_out;
  logic [DW-1:0] first_err_data, wr_data_out, rd_data_in;
  logic [15:0] err_count;
  typedef struct {int kind; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc;} ev_t;
  typedef struct {int due; logic [DW-1:0] data;} rsp_t;
  ev_t sb[$];
  rsp_t pend[$];
  logic [DW-1:0] mem [int];
  int checks = 0, errors = 0, cyc = 0, rd_seen = 0, flip_a = -1, drop_a = -1;
  int exp_err;
  bit exp_pass, exp_tmo;
  logic [AW-1:0] exp_fea;
  logic [DW-1:0] exp_fed;

  hyperram_pattern_tester dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .rd_sel(rd_sel), .wr_sel(wr_sel), .mem_sel(mem_sel), .reg_sel(reg_sel),
    .addr_out(addr_out), .wr_data_out(wr_data_out), .rd_data_in(rd_data_in), .rd_data_valid(rd_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Galois step built from the polynomial exponents x^32+x^22+x^2+x^1
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    int ex[4] = '{32, 22, 2, 1};
    logic [31:0] taps = '0;
    for (int k = 0; k < 4; k++) taps[ex[k]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  // memory echo model plus scoreboard monitor; observations tagged with the edge that samples them
  always @(negedge clk) begin
    ev_t e;
    int oc, kind;
    oc = cyc + 1;
    chk("mem_reg_sel", 64'({mem_sel, reg_sel}), 64'({rd_sel | wr_sel, 1'b0}));
    if (wr_sel) mem[int'(addr_out)] = wr_data_out;
    if (rd_sel) begin
      rd_seen++;
      if (int'(addr_out) != drop_a)
        pend.push_back('{oc + LAT, mem[int'(addr_out)] ^ ((int'(addr_out) == flip_a) ? 32'h20 : 32'h0)});
    end
    rd_data_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == oc) begin
      rd_data_valid = 1'b1;
      rd_data_in = pend[0].data;
      void'(pend.pop_front());
    end
    if (wr_sel || rd_sel || done) begin
      kind = wr_sel ? 0 : (rd_sel ? 1 : 2);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, oc);
      end else begin
        e = sb.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        chk("event_cycle", 64'(oc), 64'(e.cyc));
        if (kind != 2) chk("addr_out", 64'(addr_out), 64'(e.addr));
        if (kind == 0) chk("wr_data_out", 64'(wr_data_out), 64'(e.data));
        if (kind == 2) begin
          chk("done_err_count", 64'(err_count), 64'(exp_err));
          chk("done_pass", 64'(pass), 64'(exp_pass));
          chk("done_timeout", 64'(timeout), 64'(exp_tmo));
          chk("done_busy", 64'(busy), 64'(1));
          chk("done_first_err_addr", 64'(first_err_addr), 64'(exp_fea));
          chk("done_first_err_data", 64'(first_err_data), 64'(exp_fed));
        end
      end
    end
  end

  // fa/da: word index to corrupt/drop, -1 for none
  task automatic launch(input logic [AW-1:0] b, input int n, input int fa, input int da);
    int c0, t, first;
    logic [31:0] s;
    logic [31:0] seq[$];
    @(negedge clk);
    flip_a = (fa >= 0) ? int'(AW'(b + AW'(fa))) : -1;
    drop_a = (da >= 0) ? int'(AW'(b + AW'(da))) : -1;
    mem.delete();
    c0 = cyc + 1;
    s = SEED;
    for (int i = 0; i < n; i++) begin
      seq.push_back(s);
      s = lfsr_next(s);
    end
    for (int i = 0; i < n; i++) sb.push_back('{0, AW'(b + AW'(i)), seq[i], c0 + 1 + i * (G + 1)});
    t = c0 + 1 + n * (G + 1);
    exp_err = 0;
    first = -1;
    for (int j = 0; j < n; j++) begin
      sb.push_back('{1, AW'(b + AW'(j)), '0, t});
      if (j == da || j == fa) begin
        exp_err++;
        if (first < 0) first = j;
      end
      t += (j == da) ? TO + 1 : LAT + 1;
    end
    if (n == 0) t = c0 + 1;
    exp_pass = exp_err == 0;
    exp_tmo = da >= 0 && da < n;
`ifdef HYPERRAM_TESTER_ERR_LOG_EN
    exp_fea = (first >= 0) ? AW'(b + AW'(first)) : '0;
    exp_fed = (first < 0 || first == da) ? '0 : seq[first] ^ 32'h20;
`else
    exp_fea = '0;
    exp_fed = '0;
`endif
    sb.push_back('{2, '0, '0, t});
    base_addr = b;
    word_count = AW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
    word_count = AW'($urandom);
  endtask

  task automatic finish_run(input bit poke);
    for (int k = 0; sb.size() > 0 && k < 20000; k++) begin
      @(negedge clk);
      start = poke && k == 40;
    end
    start = 1'b0;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL run_wait: got %0d pending events expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
    chk("held_err_count", 64'(err_count), 64'(exp_err));
    chk("held_pass", 64'(pass), 64'(exp_pass));
    chk("held_timeout", 64'(timeout), 64'(exp_tmo));
    chk("idle_busy", 64'({busy, done}), 64'(0));
  endtask

  task automatic run(input logic [AW-1:0] b, input int n, input int fa, input int da, input bit poke);
    launch(b, n, fa, da);
    finish_run(poke);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 64'({busy, done, pass, timeout, err_count, rd_sel, wr_sel, mem_sel, reg_sel}), 64'(0));
    chk({name, "_addr"}, 64'({addr_out, first_err_addr}), 64'(0));
    chk({name, "_data"}, 64'({wr_data_out, first_err_data}), 64'(0));
  endtask

  initial begin
    int n, saved;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    rd_data_in = '0;
    rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    run(22'h100, 4, -1, -1, 0);
    run(22'h100, 4, 2, -1, 0);
    run(22'h100, 4, -1, 1, 0);
    run(22'h055, 0, -1, -1, 0);
    run(22'h3FFFFE, 3, -1, -1, 0);
    run(22'h200, 3, 1, -1, 1);
    launch(22'h040, 4, -1, -1);
    saved = rd_seen;
    for (int k = 0; rd_seen < saved + 2 && k < 1000; k++) @(negedge clk);
    chk("reached_read_phase", 64'(rd_seen >= saved + 2), 64'(1));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_run_reset");
    sb.delete();
    pend.delete();
    saved = rd_seen;
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("no_rd_after_reset", 64'(rd_seen), 64'(saved));
    run(22'h040, 4, -1, -1, 0);
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      run(AW'($urandom), n,
          ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1,
          ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
